// File: rtl/avcmd_rr_arbiter.sv
// Two-requester round-robin arbiter for one AVST host command channel.
// Write bursts are locked to one requester; read responses are routed back through an in-order tag FIFO.
module avcmd_rr_arbiter #(
    parameter int ADDR_WIDTH  = 48,
    parameter int DATA_WIDTH  = 512,
    parameter int BURST_WIDTH = 3,
    parameter int CMD_WIDTH   = ADDR_WIDTH + DATA_WIDTH + BURST_WIDTH + 1,
    parameter int TAG_DEPTH   = 32
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic [CMD_WIDTH-1:0]         req0_cmd_data,
    input  logic                         req0_cmd_valid,
    output logic                         req0_cmd_ready,
    input  logic [CMD_WIDTH-1:0]         req1_cmd_data,
    input  logic                         req1_cmd_valid,
    output logic                         req1_cmd_ready,

    output logic [CMD_WIDTH-1:0]         cmd_data,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,

    input  logic [DATA_WIDTH-1:0]        rsp_data,
    input  logic                         rsp_valid,
    output logic                         rsp_ready,

    output logic [DATA_WIDTH-1:0]        rsp0_data,
    output logic                         rsp0_valid,
    input  logic                         rsp0_ready,
    output logic [DATA_WIDTH-1:0]        rsp1_data,
    output logic                         rsp1_valid,
    input  logic                         rsp1_ready,

    output logic                         rsp_orphan_err,
    output logic [$clog2(TAG_DEPTH):0]   tag_count
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ARB,
        WBURST
    } state_t;

    typedef struct packed {
        logic       id;
        logic [2:0] beats;
    } tag_t;

    function automatic logic [2:0] decode_beats(input logic [BURST_WIDTH-1:0] burst);
        if (burst == BURST_WIDTH'(2))
            return 3'd2;
        else if (burst == BURST_WIDTH'(4))
            return 3'd4;
        else
            return 3'd1;
    endfunction

    state_t     state, state_n;
    logic       prio, prio_n;
    logic       lock_id, lock_id_n;
    logic [1:0] lock_cnt, lock_cnt_n;
    logic       hold_valid, hold_valid_n;
    logic       hold_id, hold_id_n;

    logic [1:0]           req_valid;
    logic                 grant;
    logic [CMD_WIDTH-1:0] sel_data;
    logic                 sel_valid;
    logic                 sel_read;
    logic [2:0]           sel_beats;
    logic                 cmd_allowed;
    logic                 grant_ready;
    logic                 xfer;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [1:0]       beat_cnt;
    tag_t             tag_mem [TAG_DEPTH];
    tag_t             head;
    logic             fifo_full, fifo_empty;
    logic             push, pop;
    logic             rsp_sel_ready;
    logic             rsp_xfer;
    logic             last_beat;

    assign req_valid = {req1_cmd_valid, req0_cmd_valid};

    // Grant source priority: burst lock, then a stalled grant, then round-robin.
    always_comb begin
        grant = prio;
        if (state == WBURST)
            grant = lock_id;
        else if (hold_valid && req_valid[hold_id])
            grant = hold_id;
        else if (req_valid[prio])
            grant = prio;
        else if (req_valid[~prio])
            grant = ~prio;
    end

    assign sel_data  = grant ? req1_cmd_data : req0_cmd_data;
    assign sel_valid = req_valid[grant];
    assign sel_read  = sel_data[0];
    assign sel_beats = decode_beats(sel_data[BURST_WIDTH:1]);

    assign fifo_full  = (count == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (count == '0);

    // Reads are refused inside a locked write burst and whenever no tag slot is free.
    assign cmd_allowed = (state == WBURST) ? !sel_read : (!sel_read || !fifo_full);

    assign cmd_data       = sel_data;
    assign cmd_valid      = !reset && sel_valid && cmd_allowed;
    assign grant_ready    = !reset && cmd_ready && cmd_allowed;
    assign req0_cmd_ready = grant_ready && (grant == 1'b0);
    assign req1_cmd_ready = grant_ready && (grant == 1'b1);
    assign xfer           = cmd_valid && cmd_ready;

    // NOTE: every next-state variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_n      = state;
        prio_n       = prio;
        lock_id_n    = lock_id;
        lock_cnt_n   = lock_cnt;
        hold_valid_n = hold_valid;
        hold_id_n    = hold_id;
        case (state)
            ARB: begin
                if (xfer) begin
                    hold_valid_n = 1'b0;
                    if (!sel_read && sel_beats != 3'd1) begin
                        lock_cnt_n = 2'(sel_beats - 3'd1);
                        lock_id_n  = grant;
                        state_n    = WBURST;
                    end else begin
                        prio_n = ~grant;
                    end
                end else if (sel_valid) begin
                    hold_valid_n = 1'b1;
                    hold_id_n    = grant;
                end else begin
                    hold_valid_n = 1'b0;
                end
            end
            WBURST: begin
                if (xfer) begin
                    lock_cnt_n = lock_cnt - 2'd1;
                    if (lock_cnt == 2'd1) begin
                        state_n = ARB;
                        prio_n  = ~lock_id;
                    end
                end
            end
            default: state_n = ARB;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB;
            prio       <= 1'b0;
            lock_id    <= 1'b0;
            lock_cnt   <= 2'd0;
            hold_valid <= 1'b0;
            hold_id    <= 1'b0;
        end else begin
            state      <= state_n;
            prio       <= prio_n;
            lock_id    <= lock_id_n;
            lock_cnt   <= lock_cnt_n;
            hold_valid <= hold_valid_n;
            hold_id    <= hold_id_n;
        end
    end

    assign push = xfer && sel_read;
    assign head = tag_mem[rd_ptr];

    assign rsp_sel_ready = head.id ? rsp1_ready : rsp0_ready;
    assign rsp_ready     = !reset && !fifo_empty && rsp_sel_ready;
    assign rsp0_valid    = !reset && rsp_valid && !fifo_empty && (head.id == 1'b0);
    assign rsp1_valid    = !reset && rsp_valid && !fifo_empty && (head.id == 1'b1);
    assign rsp0_data     = rsp_data;
    assign rsp1_data     = rsp_data;
    assign rsp_xfer      = rsp_valid && rsp_ready;
    assign last_beat     = (beat_cnt == 2'(head.beats - 3'd1));
    assign pop           = rsp_xfer && last_beat;

    assign tag_count = count;

    // NOTE: tag storage has no reset; entries are only read while the occupancy count says they are valid.
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= '{id: grant, beats: sel_beats};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            beat_cnt       <= 2'd0;
            rsp_orphan_err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                beat_cnt <= 2'd0;
            end else if (rsp_xfer) begin
                beat_cnt <= beat_cnt + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (rsp_valid && fifo_empty)
                rsp_orphan_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avcmd_rr_arbiter.sv
// Directed bench for avcmd_rr_arbiter: queue-fed requester/response drivers and
// a scoreboard of expected command grants and routed response beats.
module tb_avcmd_rr_arbiter;

    localparam int AW  = 48;
    localparam int DW  = 512;
    localparam int BW  = 3;
    localparam int CW  = AW + DW + BW + 1;
    localparam int TD  = 32;
    localparam int TCW = $clog2(TD) + 1;

    typedef struct packed {
        logic          id;
        logic [CW-1:0] data;
    } cmd_exp_t;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
    } rsp_exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [CW-1:0]  req0_cmd_data = '0;
    logic           req0_cmd_valid = 1'b0;
    logic           req0_cmd_ready;
    logic [CW-1:0]  req1_cmd_data = '0;
    logic           req1_cmd_valid = 1'b0;
    logic           req1_cmd_ready;
    logic [CW-1:0]  cmd_data;
    logic           cmd_valid;
    logic           cmd_ready = 1'b0;
    logic [DW-1:0]  rsp_data = '0;
    logic           rsp_valid = 1'b0;
    logic           rsp_ready;
    logic [DW-1:0]  rsp0_data;
    logic           rsp0_valid;
    logic           rsp0_ready = 1'b0;
    logic [DW-1:0]  rsp1_data;
    logic           rsp1_valid;
    logic           rsp1_ready = 1'b0;
    logic           rsp_orphan_err;
    logic [TCW-1:0] tag_count;

    avcmd_rr_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_WIDTH(BW),
        .CMD_WIDTH  (CW),
        .TAG_DEPTH  (TD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req0_cmd_data (req0_cmd_data),
        .req0_cmd_valid(req0_cmd_valid),
        .req0_cmd_ready(req0_cmd_ready),
        .req1_cmd_data (req1_cmd_data),
        .req1_cmd_valid(req1_cmd_valid),
        .req1_cmd_ready(req1_cmd_ready),
        .cmd_data      (cmd_data),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .rsp_data      (rsp_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp0_data     (rsp0_data),
        .rsp0_valid    (rsp0_valid),
        .rsp0_ready    (rsp0_ready),
        .rsp1_data     (rsp1_data),
        .rsp1_valid    (rsp1_valid),
        .rsp1_ready    (rsp1_ready),
        .rsp_orphan_err(rsp_orphan_err),
        .tag_count     (tag_count)
    );

    always #5 clk = ~clk;

    logic [CW-1:0] q0[$];
    logic [CW-1:0] q1[$];
    logic [DW-1:0] rsp_src[$];
    cmd_exp_t      exp_cmd[$];
    rsp_exp_t      exp_rsp[$];

    int   checks = 0;
    int   errors = 0;
    logic acc0 = 1'b0;
    logic acc1 = 1'b0;
    logic acc_rsp = 1'b0;

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dat(input int i);
        return {16{32'(i) ^ 32'hA5A5_0000}};
    endfunction

    function automatic logic [CW-1:0] mk_cmd(input logic [AW-1:0] addr, input logic [BW-1:0] burst,
                                             input logic rd, input int i);
        return {addr, dat(i), burst, rd};
    endfunction

    // Scoreboard: sample handshakes on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cmd_exp_t ce;
        rsp_exp_t re;
        acc0    = req0_cmd_valid && req0_cmd_ready;
        acc1    = req1_cmd_valid && req1_cmd_ready;
        acc_rsp = rsp_valid && rsp_ready;
        if (cmd_valid && cmd_ready) begin
            check("cmd_sb_entry", 640'(exp_cmd.size() != 0), 640'(1'b1));
            if (exp_cmd.size() != 0) begin
                ce = exp_cmd.pop_front();
                check("cmd_grant", 640'(acc1), 640'(ce.id));
                check("cmd_data", 640'(cmd_data), 640'(ce.data));
            end
            check("cmd_one_ready", 640'(acc0 ^ acc1), 640'(1'b1));
        end
        if (rsp0_valid || rsp1_valid)
            check("rsp_onehot", 640'(rsp0_valid && rsp1_valid), 640'(1'b0));
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
            check("rsp_sb_entry", 640'(exp_rsp.size() != 0), 640'(1'b1));
            check("rsp_consumed", 640'(rsp_ready), 640'(1'b1));
            if (exp_rsp.size() != 0) begin
                re = exp_rsp.pop_front();
                check("rsp_dest", 640'(rsp1_valid), 640'(re.id));
                check("rsp_data", 640'(rsp1_valid ? rsp1_data : rsp0_data), 640'(re.data));
            end
        end
    end

    // Requester and host-response drivers, fed from the stimulus queues.
    always @(posedge clk) begin
        #1;
        if (acc0 && q0.size() != 0) void'(q0.pop_front());
        if (acc1 && q1.size() != 0) void'(q1.pop_front());
        if (acc_rsp && rsp_src.size() != 0) void'(rsp_src.pop_front());
        req0_cmd_valid = (q0.size() != 0);
        if (q0.size() != 0) req0_cmd_data = q0[0];
        req1_cmd_valid = (q1.size() != 0);
        if (q1.size() != 0) req1_cmd_data = q1[0];
        rsp_valid = (rsp_src.size() != 0);
        if (rsp_src.size() != 0) rsp_data = rsp_src[0];
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_xfer(input string tag, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            seen = cmd_valid && cmd_ready;
        end
        check(tag, 640'(seen), 640'(1'b1));
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            seen = rsp_valid && rsp_ready;
        end
        check(tag, 640'(seen), 640'(1'b1));
    endtask

    task automatic wait_drain(input string tag, input int budget);
        bit done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            #1;
            done = q0.size() == 0 && q1.size() == 0 && rsp_src.size() == 0 &&
                   exp_cmd.size() == 0 && exp_rsp.size() == 0;
        end
        check(tag, 640'(done), 640'(1'b1));
    endtask

    initial begin
        int  xf;
        bit  seen;

        // Reset state
        step(3);
        @(negedge clk);
        check("rst_tag_count", 640'(tag_count), 640'(0));
        check("rst_cmd_valid", 640'(cmd_valid), 640'(1'b0));
        check("rst_req0_ready", 640'(req0_cmd_ready), 640'(1'b0));
        check("rst_rsp_ready", 640'(rsp_ready), 640'(1'b0));
        check("rst_orphan", 640'(rsp_orphan_err), 640'(1'b0));
        step();
        reset      = 1'b0;
        cmd_ready  = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        step();

        // Both requesters stream 1-beat reads: grants alternate, one tag per cycle
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk_cmd(AW'('h100 + i), 3'd1, 1'b1, i));
            q1.push_back(mk_cmd(AW'('h200 + i), 3'd1, 1'b1, 10 + i));
            exp_cmd.push_back('{id: 1'b0, data: mk_cmd(AW'('h100 + i), 3'd1, 1'b1, i)});
            exp_cmd.push_back('{id: 1'b1, data: mk_cmd(AW'('h200 + i), 3'd1, 1'b1, 10 + i)});
        end
        wait_xfer("t1_start", 20);
        for (int k = 0; k < 8; k++) begin
            check("t1_tag_count", 640'(tag_count), 640'(k));
            check("t1_back_to_back", 640'(cmd_valid && cmd_ready), 640'(1'b1));
            @(negedge clk);
        end
        check("t1_tag_count_final", 640'(tag_count), 640'(8));
        step();
        for (int i = 0; i < 8; i++) begin
            rsp_src.push_back(dat(50 + i));
            exp_rsp.push_back('{id: 1'(i % 2), data: dat(50 + i)});
        end
        wait_drain("t1_drain", 50);
        check("t1_tag_empty", 640'(tag_count), 640'(0));

        // 4-beat write from req0 locks out a pending req1 read
        step();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk_cmd(AW'('h1000), 3'd4, 1'b0, 20 + i));
            exp_cmd.push_back('{id: 1'b0, data: mk_cmd(AW'('h1000), 3'd4, 1'b0, 20 + i)});
        end
        q1.push_back(mk_cmd(AW'('h2000), 3'd1, 1'b1, 30));
        exp_cmd.push_back('{id: 1'b1, data: mk_cmd(AW'('h2000), 3'd1, 1'b1, 30)});
        wait_xfer("t2_start", 20);
        for (int k = 0; k < 4; k++) begin
            check("t2_req0_beat", 640'(req0_cmd_ready && cmd_valid), 640'(1'b1));
            check("t2_req1_blocked", 640'(req1_cmd_ready), 640'(1'b0));
            @(negedge clk);
        end
        check("t2_req1_granted", 640'(req1_cmd_ready && cmd_valid), 640'(1'b1));
        step();
        rsp_src.push_back(dat(100));
        exp_rsp.push_back('{id: 1'b1, data: dat(100)});
        wait_drain("t2_drain", 30);

        // 2-beat write under a toggling cmd_ready, then prio must favour req1
        step();
        cmd_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            q0.push_back(mk_cmd(AW'('h3000), 3'd2, 1'b0, 40 + i));
            exp_cmd.push_back('{id: 1'b0, data: mk_cmd(AW'('h3000), 3'd2, 1'b0, 40 + i)});
        end
        step(2);
        xf = 0;
        for (int c = 0; c < 4; c++) begin
            cmd_ready = (c % 2 == 0);
            @(negedge clk);
            if (cmd_valid && cmd_ready) xf++;
            if (c == 1) check("t3_lock_holds_valid", 640'(cmd_valid), 640'(1'b1));
            step();
        end
        check("t3_xfers", 640'(xf), 640'(2));
        cmd_ready = 1'b1;
        q0.push_back(mk_cmd(AW'('h3100), 3'd1, 1'b1, 42));
        q1.push_back(mk_cmd(AW'('h3200), 3'd1, 1'b1, 43));
        exp_cmd.push_back('{id: 1'b1, data: mk_cmd(AW'('h3200), 3'd1, 1'b1, 43)});
        exp_cmd.push_back('{id: 1'b0, data: mk_cmd(AW'('h3100), 3'd1, 1'b1, 42)});
        wait_drain("t3_cmd", 30);
        step();
        rsp_src.push_back(dat(110));
        rsp_src.push_back(dat(111));
        exp_rsp.push_back('{id: 1'b1, data: dat(110)});
        exp_rsp.push_back('{id: 1'b0, data: dat(111)});
        wait_drain("t3_drain", 30);

        // 2-beat read (req0) then 4-beat read (req1): routing switch without a bubble
        step();
        q0.push_back(mk_cmd(AW'('h4000), 3'd2, 1'b1, 60));
        exp_cmd.push_back('{id: 1'b0, data: mk_cmd(AW'('h4000), 3'd2, 1'b1, 60)});
        wait_drain("t4_cmd0", 20);
        step();
        q1.push_back(mk_cmd(AW'('h4100), 3'd4, 1'b1, 61));
        exp_cmd.push_back('{id: 1'b1, data: mk_cmd(AW'('h4100), 3'd4, 1'b1, 61)});
        wait_drain("t4_cmd1", 20);
        check("t4_tag_count", 640'(tag_count), 640'(2));
        step();
        for (int i = 0; i < 6; i++) begin
            rsp_src.push_back(dat(i));
            exp_rsp.push_back('{id: (i >= 2), data: dat(i)});
        end
        wait_rsp("t4_rsp_start", 20);
        for (int k = 0; k < 6; k++) begin
            check("t4_rsp_no_bubble", 640'(rsp_valid && rsp_ready), 640'(1'b1));
            check("t4_rsp1_sel", 640'(rsp1_valid), 640'(k >= 2));
            @(negedge clk);
        end
        wait_drain("t4_drain", 20);
        check("t4_tag_empty", 640'(tag_count), 640'(0));

        // Fill the tag FIFO, then free one slot with a single response beat
        step();
        for (int i = 0; i < 17; i++) begin
            q0.push_back(mk_cmd(AW'('h5000 + i), 3'd1, 1'b1, 200 + i));
            q1.push_back(mk_cmd(AW'('h6000 + i), 3'd1, 1'b1, 300 + i));
            exp_cmd.push_back('{id: 1'b0, data: mk_cmd(AW'('h5000 + i), 3'd1, 1'b1, 200 + i)});
            exp_cmd.push_back('{id: 1'b1, data: mk_cmd(AW'('h6000 + i), 3'd1, 1'b1, 300 + i)});
        end
        seen = 1'b0;
        for (int n = 0; n < 80 && !seen; n++) begin
            @(negedge clk);
            seen = (tag_count == TCW'(TD));
        end
        @(negedge clk);
        check("t5_tag_full", 640'(tag_count), 640'(TD));
        check("t5_req0_ready_full", 640'(req0_cmd_ready), 640'(1'b0));
        check("t5_req1_ready_full", 640'(req1_cmd_ready), 640'(1'b0));
        check("t5_cmd_valid_full", 640'(cmd_valid), 640'(1'b0));
        step();
        rsp_src.push_back(dat(400));
        exp_rsp.push_back('{id: 1'b0, data: dat(400)});
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = (q0.size() == 0);
        end
        check("t5_read_after_pop", 640'(seen), 640'(1'b1));
        @(negedge clk);
        check("t5_refilled", 640'(tag_count), 640'(TD));
        step();
        for (int j = 1; j < 34; j++) begin
            rsp_src.push_back(dat(400 + j));
            exp_rsp.push_back('{id: 1'(j % 2), data: dat(400 + j)});
        end
        wait_drain("t5_drain", 200);
        check("t5_tag_empty", 640'(tag_count), 640'(0));

        // Orphan response beat with an empty tag FIFO
        step();
        rsp_src.push_back(dat(999));
        step(3);
        @(negedge clk);
        check("t6_orphan_ready", 640'(rsp_ready), 640'(1'b0));
        check("t6_orphan_rsp0", 640'(rsp0_valid), 640'(1'b0));
        check("t6_orphan_rsp1", 640'(rsp1_valid), 640'(1'b0));
        check("t6_orphan_err", 640'(rsp_orphan_err), 640'(1'b1));
        step();
        rsp_src.delete();
        step(3);
        @(negedge clk);
        check("t6_orphan_sticky", 640'(rsp_orphan_err), 640'(1'b1));

        // Reset in the middle of a req1 write burst
        step();
        for (int i = 0; i < 4; i++) begin
            q1.push_back(mk_cmd(AW'('h7000), 3'd4, 1'b0, 500 + i));
            exp_cmd.push_back('{id: 1'b1, data: mk_cmd(AW'('h7000), 3'd4, 1'b0, 500 + i)});
        end
        wait_xfer("t7_start", 20);
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        q0.delete();
        q1.delete();
        exp_cmd.delete();
        #1;
        check("t7_rst_cmd_valid", 640'(cmd_valid), 640'(1'b0));
        check("t7_rst_req0_ready", 640'(req0_cmd_ready), 640'(1'b0));
        check("t7_rst_req1_ready", 640'(req1_cmd_ready), 640'(1'b0));
        check("t7_rst_rsp_ready", 640'(rsp_ready), 640'(1'b0));
        check("t7_rst_rsp_valid", 640'({rsp0_valid, rsp1_valid}), 640'(2'b00));
        check("t7_rst_orphan", 640'(rsp_orphan_err), 640'(1'b0));
        check("t7_rst_tag_count", 640'(tag_count), 640'(0));
        step(2);
        reset = 1'b0;
        q0.push_back(mk_cmd(AW'('h8000), 3'd1, 1'b0, 600));
        q1.push_back(mk_cmd(AW'('h8100), 3'd1, 1'b0, 601));
        exp_cmd.push_back('{id: 1'b0, data: mk_cmd(AW'('h8000), 3'd1, 1'b0, 600)});
        exp_cmd.push_back('{id: 1'b1, data: mk_cmd(AW'('h8100), 3'd1, 1'b0, 601)});
        wait_drain("t7_after_reset", 20);
        check("t7_orphan_cleared", 640'(rsp_orphan_err), 640'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/avcmd_rr_arbiter.md
Name: avcmd_rr_arbiter

Overview:
- Shares one AVST host command channel (addr/write_data/burst/control word) between two DMA requesters, e.g. the read master and the write master.
- Write bursts are never interleaved.
- For every accepted read, the block records the requester ID and burst length in an in-order tag FIFO, and uses it to route returning read-response beats to the requester that issued them.
- Sits between the DMA masters and the CCI-P host bridge.

Parameters:
- ADDR_WIDTH, 48, command address field width.
- DATA_WIDTH, 512, write-data and read-response width.
- BURST_WIDTH, 3, burst field width; legal values 1, 2, 4.
- CMD_WIDTH, ADDR_WIDTH+DATA_WIDTH+BURST_WIDTH+1, command word width. Packing MSB→LSB: addr, write_data, burst, control[0] (1 = read, 0 = write).
- TAG_DEPTH, 32, outstanding read commands tracked; power of 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req0_cmd_data  in  CMD_WIDTH  requester 0 command word.
- req0_cmd_valid  in  1  requester 0 command valid.
- req0_cmd_ready  out  1  requester 0 command accepted.
- req1_cmd_data  in  CMD_WIDTH  requester 1 command word.
- req1_cmd_valid  in  1  requester 1 command valid.
- req1_cmd_ready  out  1  requester 1 command accepted.
- cmd_data  out  CMD_WIDTH  command to host bridge.
- cmd_valid  out  1  command valid to host bridge.
- cmd_ready  in  1  host bridge ready.
- rsp_data  in  DATA_WIDTH  read-response beat from host bridge.
- rsp_valid  in  1  response beat valid.
- rsp_ready  out  1  response beat accepted.
- rsp0_data  out  DATA_WIDTH  routed response to requester 0.
- rsp0_valid  out  1  routed response valid, requester 0.
- rsp0_ready  in  1  requester 0 response ready.
- rsp1_data  out  DATA_WIDTH  routed response to requester 1.
- rsp1_valid  out  1  routed response valid, requester 1.
- rsp1_ready  in  1  requester 1 response ready.
- rsp_orphan_err  out  1  sticky: a response beat arrived with no outstanding read.
- tag_count  out  $clog2(TAG_DEPTH)+1  occupancy of the tag FIFO.

Behaviour:
- Reset (async):
  - State = ARB; lock_cnt = 0; priority pointer prio = 0 (req0 preferred).
  - Tag FIFO empty; response beat counter = 0; rsp_orphan_err = 0.
  - All valid/ready outputs 0 while reset is asserted. A reset mid-burst or mid-response discards all tracking state.
- Burst decode: burst field 2 → 2 beats; 4 → 4 beats; any other value → 1 beat.
- Command path is combinational, zero latency:
  - cmd_data/cmd_valid = selected requester's data/valid.
  - reqN_cmd_ready = cmd_ready & (grant == N) & (read command ? tag FIFO not full : 1).
  - cmd_valid is gated by the same full condition, so a read is never presented while the FIFO is full.
- A beat transfers on cmd_valid & cmd_ready.
- FSM:
  - ARB:
    - Grant = prio if that requester's valid is set, else the other requester if its valid is set; grant is held stable while the cycle does not transfer.
    - On transfer of a read, or a 1-beat write: stay in ARB; prio ← other requester.
    - On transfer of the first beat of a 2- or 4-beat write: lock_cnt ← beats-1; go to WBURST with grant frozen.
  - WBURST:
    - Only the locked requester is served; the other requester's ready = 0.
    - Each transfer decrements lock_cnt.
    - On the transfer that takes lock_cnt from 1 to 0: go to ARB; prio ← other requester.
    - Read commands from the locked requester while in WBURST are a protocol violation and are not accepted; ready follows the write rule only when control[0] = 0.
- Tag FIFO:
  - Push {id, beats} on every read transfer.
  - Pop when the last response beat of the head entry transfers.
  - Push while full does not occur (gated). A simultaneous push and pop is allowed; occupancy is unchanged.
- Response routing:
  - Head entry selects the destination.
  - rspN_valid = rsp_valid & FIFO not empty & head.id == N.
  - rspN_data = rsp_data to both outputs.
  - rsp_ready = FIFO not empty & ready of the selected requester.
  - Beat counter increments per transferred beat. At head.beats-1 it clears and the entry pops; the next beat routes per the new head in the very next cycle, with no bubble.
- Empty FIFO with rsp_valid = 1: rsp_ready = 0, the beat is not consumed, and rsp_orphan_err sets and stays set until reset.
- Responses are guaranteed to arrive in command order by the host path.

Test Plan:
- Both requesters continuously issue 1-beat reads, cmd_ready = 1 → grants alternate 0,1,0,1; tag_count rises by 1 per cycle until responses drain.
- req0 issues a 4-beat write (addr 0x1000) while req1 holds a read valid → 4 consecutive req0 beats, req1_cmd_ready = 0 throughout, then the req1 read is granted on cycle 5.
- cmd_ready toggles 1,0,1,0 during a 2-beat write → lock holds across stalls; exactly 2 transfers, then ARB with prio switched.
- req0 issues a 2-beat read, then req1 a 4-beat read; 6 response beats arrive with data 0..5 → beats 0–1 go to rsp0, beats 2–5 go to rsp1, with no bubble at the switch.
- Fill 32 reads with no responses → tag_count = 32, both cmd_ready = 0 for reads; one response beat pops an entry and the next read is accepted.
- rsp_valid asserted with an empty FIFO → rsp_ready = 0, rsp_orphan_err = 1 and stays set; assert reset mid-WBURST → state back to ARB, all outputs 0.
